// File: rtl/laser_score.sv
// laser_score: snoops the engine's target points, then re-scores the
// engine's two circle centres one point per cycle and pulses VALID.
module laser_score #(
  parameter int OBJ_NUM   = 40,
  parameter int RADIUS_SQ = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [5:0] COVER,
  output logic [5:0] C1_CNT,
  output logic [5:0] C2_CNT,
  output logic       VALID
);

  localparam logic [5:0] LAST = 6'(OBJ_NUM - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_EVAL,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0] pts [OBJ_NUM];
  logic [5:0] load_cnt;
  logic [5:0] idx;
  logic [3:0] c1x_q, c1y_q, c2x_q, c2y_q;
  logic [5:0] cov_acc, c1_acc, c2_acc;

  logic load_en, cap_en, eval_en, out_en;
  logic [7:0] pt;
  logic in1, in2;

  function automatic logic inside_c(
    input logic [3:0] px,
    input logic [3:0] py,
    input logic [3:0] cx,
    input logic [3:0] cy
  );
    logic [3:0] dx, dy;
    logic [8:0] ex, ey, d2;
    dx = (px >= cx) ? px - cx : cx - px;
    dy = (py >= cy) ? py - cy : cy - py;
    ex = {5'b0, dx};
    ey = {5'b0, dy};
    d2 = ex * ex + ey * ey;
    return d2 <= 9'(RADIUS_SQ);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state <= S_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LOAD: if (load_en && load_cnt == LAST) state_nx = S_WAIT;
      S_WAIT: if (DONE) state_nx = S_EVAL;
      S_EVAL: if (idx == LAST) state_nx = S_OUT;
      S_OUT:  state_nx = S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  // VALID still high means a new image may not start this cycle
  always_comb begin
    load_en = 1'b0;
    cap_en  = 1'b0;
    eval_en = 1'b0;
    out_en  = 1'b0;
    unique case (state)
      S_LOAD: load_en = IN_VALID && !VALID;
      S_WAIT: cap_en  = DONE;
      S_EVAL: eval_en = 1'b1;
      S_OUT:  out_en  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (load_en) pts[load_cnt] <= {Y, X};
  end

  assign pt  = pts[idx];
  assign in1 = inside_c(pt[3:0], pt[7:4], c1x_q, c1y_q);
  assign in2 = inside_c(pt[3:0], pt[7:4], c2x_q, c2y_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_cnt <= '0;
      idx      <= '0;
      c1x_q    <= '0;
      c1y_q    <= '0;
      c2x_q    <= '0;
      c2y_q    <= '0;
      cov_acc  <= '0;
      c1_acc   <= '0;
      c2_acc   <= '0;
      COVER    <= '0;
      C1_CNT   <= '0;
      C2_CNT   <= '0;
      VALID    <= 1'b0;
    end else begin
      VALID <= out_en;
      if (load_en) begin
        if (load_cnt == LAST) load_cnt <= '0;
        else                  load_cnt <= load_cnt + 6'd1;
      end
      if (cap_en) begin
        c1x_q   <= C1X;
        c1y_q   <= C1Y;
        c2x_q   <= C2X;
        c2y_q   <= C2Y;
        cov_acc <= '0;
        c1_acc  <= '0;
        c2_acc  <= '0;
        idx     <= '0;
      end
      if (eval_en) begin
        cov_acc <= cov_acc + {5'b0, in1 | in2};
        c1_acc  <= c1_acc + {5'b0, in1};
        c2_acc  <= c2_acc + {5'b0, in2};
        idx     <= (idx == LAST) ? '0 : idx + 6'd1;
      end
      if (out_en) begin
        COVER  <= cov_acc;
        C1_CNT <= c1_acc;
        C2_CNT <= c2_acc;
      end
    end
  end

endmodule

// File: tb/tb_laser_score.sv
// Scoreboard bench for laser_score: directed images, expected counts
// and VALID arrival cycle queued at DONE time, checked by a monitor.
module tb_laser_score;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic [3:0] X, Y;
  logic       DONE;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic [5:0] COVER, C1_CNT, C2_CNT;
  logic       VALID;

  laser_score dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y),
    .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .COVER(COVER), .C1_CNT(C1_CNT), .C2_CNT(C2_CNT), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cov;
    int c1;
    int c2;
    int cyc;
    string name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // monitor: every VALID pulse must match the oldest queued result
  always @(negedge CLK) begin
    if (!RST && VALID) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_cover"}, int'(COVER), e.cov);
        check({e.name, "_c1"}, int'(C1_CNT), e.c1);
        check({e.name, "_c2"}, int'(C2_CNT), e.c2);
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic send_pts(input int n, input int x, input int y);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      X = 4'(x);
      Y = 4'(y);
      @(posedge CLK);
      #1 IN_VALID = 1'b0;
    end
  endtask

  // hold > 1 gives a multi-cycle DONE; push=0 for a DONE that is dropped
  task automatic done(input int c1x, input int c1y, input int c2x,
                      input int c2y, input int hold, input bit push,
                      input int ec, input int e1, input int e2,
                      input string nm);
    @(negedge CLK);
    DONE = 1'b1;
    C1X = 4'(c1x); C1Y = 4'(c1y);
    C2X = 4'(c2x); C2Y = 4'(c2y);
    if (push) sb.push_back('{ec, e1, e2, cyc + 1 + 41, nm});
    repeat (hold) @(posedge CLK);
    #1 DONE = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!VALID && k < 100);
    if (!VALID) check({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    RST = 1'b1;
    IN_VALID = 1'b0;
    X = '0; Y = '0;
    DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cover", int'(COVER), 0);
    check("rst_c1", int'(C1_CNT), 0);
    check("rst_c2", int'(C2_CNT), 0);
    check("rst_valid", int'(VALID), 0);
    RST = 1'b0;

    send_pts(40, 0, 0);
    done(0, 0, 15, 15, 1, 1, 40, 40, 0, "all_origin");
    wait_valid("all_origin");

    send_pts(1, 4, 0);
    send_pts(1, 3, 2);
    send_pts(1, 2, 3);
    send_pts(1, 4, 1);
    send_pts(36, 15, 0);
    done(0, 0, 15, 15, 1, 1, 3, 3, 0, "boundary");
    wait_valid("boundary");

    // next image starts the cycle after VALID; old results must hold
    send_pts(20, 7, 7);
    check("hold_cover", int'(COVER), 3);
    check("hold_c1", int'(C1_CNT), 3);
    send_pts(20, 9, 7);
    check("hold_c2", int'(C2_CNT), 0);
    done(7, 7, 9, 7, 1, 1, 40, 40, 40, "overlap");
    wait_valid("overlap");

    send_pts(10, 5, 5);
    done(5, 5, 0, 0, 1, 0, 0, 0, 0, "early_done");
    send_pts(30, 0, 0);
    done(5, 5, 0, 0, 1, 1, 40, 10, 30, "premature");
    wait_valid("premature");

    send_pts(40, 3, 3);
    done(3, 3, 3, 3, 1, 0, 0, 0, 0, "aborted");
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_cover", int'(COVER), 0);
    check("abort_c1", int'(C1_CNT), 0);
    check("abort_c2", int'(C2_CNT), 0);
    check("abort_valid", int'(VALID), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (50) @(posedge CLK);

    send_pts(20, 8, 8);
    send_pts(20, 1, 1);
    done(10, 10, 1, 4, 3, 1, 40, 20, 20, "reload_hold");
    wait_valid("reload_hold");

    repeat (60) @(posedge CLK);
    @(negedge CLK);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
